// File: rtl/af_diff_tap_line_if.sv
// rtl/af_diff_tap_line_if.sv - sample input stream and folded-difference output stream
interface af_diff_tap_line_if #(
    parameter int DATA_WIDTH = 14,
    parameter int TAPS       = 10
);
    localparam int DIFF_WIDTH = (TAPS / 2) * (DATA_WIDTH + 1);

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DIFF_WIDTH-1:0] m_diff;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_diff
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_diff
    );
endinterface

// File: rtl/af_diff_tap_line.sv
// rtl/af_diff_tap_line.sv - tap history and pre-subtractor for the antisymmetric differentiator FIR
module af_diff_tap_line #(
    parameter int DATA_WIDTH = 14,
    parameter int TAPS       = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    af_diff_tap_line_if.slave    bus,
    output logic [3:0]           fill_cnt
);
    localparam int         FOLD = TAPS / 2;
    localparam int         DW1  = DATA_WIDTH + 1;
    localparam logic [3:0] FULL = 4'(TAPS);

    typedef enum logic {FILL, RUN} state_t;

    state_t                       state;
    state_t                       state_next;
    logic signed [DATA_WIDTH-1:0] taps    [TAPS];
    logic signed [DATA_WIDTH-1:0] shifted [TAPS];
    logic [FOLD*DW1-1:0]          diff_next;
    logic [FOLD*DW1-1:0]          m_diff_r;
    logic                         m_valid_r;
    logic                         accept;
    logic                         produce;

    assign bus.s_ready = ~flush & (~m_valid_r | bus.m_ready);
    assign accept      = bus.s_valid & bus.s_ready;
    assign bus.m_valid = m_valid_r;
    assign bus.m_diff  = m_diff_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush)
            state_next = FILL;
        else if (state == FILL && accept && fill_cnt == FULL - 4'd1)
            state_next = RUN;
    end

    // The accept that completes the history already yields the first word.
    always_comb begin
        produce = 1'b0;
        if (accept && (state == RUN || fill_cnt == FULL - 4'd1))
            produce = 1'b1;
    end

    always_comb begin
        shifted[0] = bus.s_data;
        for (int i = 1; i < TAPS; i++)
            shifted[i] = taps[i-1];
    end

    always_comb begin
        diff_next = '0;
        for (int k = 0; k < FOLD; k++)
            diff_next[k*DW1 +: DW1] = {shifted[k][DATA_WIDTH-1], shifted[k]}
                                    - {shifted[TAPS-1-k][DATA_WIDTH-1], shifted[TAPS-1-k]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) taps[i] <= '0;
            fill_cnt  <= '0;
            m_valid_r <= 1'b0;
            m_diff_r  <= '0;
        end else if (flush) begin
            for (int i = 0; i < TAPS; i++) taps[i] <= '0;
            fill_cnt  <= '0;
            m_valid_r <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < TAPS; i++) taps[i] <= shifted[i];
                if (fill_cnt != FULL) fill_cnt <= fill_cnt + 4'd1;
            end
            if (produce) begin
                m_diff_r  <= diff_next;
                m_valid_r <= 1'b1;
            end else if (bus.m_ready) begin
                m_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_af_diff_tap_line.sv
// tb/tb_af_diff_tap_line.sv - randomized self-checking bench for af_diff_tap_line
module tb_af_diff_tap_line;
    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [3:0] fill_cnt;

    af_diff_tap_line_if #(.DATA_WIDTH(14), .TAPS(10)) bus ();

    af_diff_tap_line #(.DATA_WIDTH(14), .TAPS(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .fill_cnt (fill_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          total = 0;
    int          bad   = 0;

    // reference model: newest sample at the front of hist
    int          hist[$];
    int          cnt;
    logic        mv;
    logic [74:0] md;
    logic        exp_rdy;
    logic        act_rdy;

    task automatic model_clear();
        hist.delete();
        cnt = 0;
        mv  = 1'b0;
        md  = '0;
    endtask

    task automatic cycle(input logic sv, input logic [13:0] sd, input logic mr, input logic fl);
        logic acc;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        flush       = fl;
        #1;
        act_rdy = bus.s_ready;
        exp_rdy = !fl && (!mv || mr);
        @(posedge clk);
        #1;
        acc = sv && exp_rdy;
        if (fl) begin
            hist.delete();
            cnt = 0;
            mv  = 1'b0;
        end else begin
            if (acc) begin
                hist.push_front(int'($signed(sd)));
                if (hist.size() > 10) void'(hist.pop_back());
                if (cnt < 10) cnt++;
            end
            if (acc && cnt == 10) begin
                mv = 1'b1;
                for (int k = 0; k < 5; k++) md[k*15 +: 15] = 15'(hist[k] - hist[9-k]);
            end else if (mr) begin
                mv = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1; flush = 1'b0;
        model_clear();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%0b exp=1", bus.s_ready); end
        total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b exp=0", bus.m_valid); end
        total++; if (bus.m_diff !== 75'd0) begin bad++; $display("FAIL reset_m_diff got=%h exp=0", bus.m_diff); end
        total++; if (fill_cnt !== 4'd0) begin bad++; $display("FAIL reset_fill_cnt got=%0d exp=0", fill_cnt); end
        @(negedge clk);
    endtask

    task automatic test_fill(input string tag);
        int expd[5];
        expd = '{9, 7, 5, 3, 1};
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 14'(i), 1'b1, 1'b0);
            total++;
            if (bus.m_valid !== (i == 10)) begin
                bad++; $display("FAIL %s_m_valid accept=%0d got=%0b exp=%0b", tag, i, bus.m_valid, i == 10);
            end
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (bus.m_diff[k*15 +: 15] !== 15'(expd[k])) begin
                bad++; $display("FAIL %s_d%0d got=%0d exp=%0d", tag, k, bus.m_diff[k*15 +: 15], expd[k]);
            end
        end
        total++; if (fill_cnt !== 4'd10) begin bad++; $display("FAIL %s_fill_cnt got=%0d exp=10", tag, fill_cnt); end
    endtask

    task automatic test_extremes();
        for (int i = 0; i < 10; i++)
            cycle(1'b1, (i % 2 == 0) ? 14'h2000 : 14'h1FFF, 1'b1, 1'b0);
        total++; if (bus.m_diff[14:0] !== 15'h3FFF) begin bad++; $display("FAIL ext_pos_d0 got=%h exp=3fff", bus.m_diff[14:0]); end
        cycle(1'b1, 14'h2000, 1'b1, 1'b0);
        total++; if (bus.m_diff[14:0] !== 15'h4001) begin bad++; $display("FAIL ext_neg_d0 got=%h exp=4001", bus.m_diff[14:0]); end
        total++; if (bus.m_diff !== md) begin bad++; $display("FAIL ext_model got=%h exp=%h", bus.m_diff, md); end
    endtask

    task automatic test_backpressure();
        logic [74:0] hold;
        cycle(1'b1, 14'($urandom), 1'b1, 1'b0);
        hold = bus.m_diff;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 14'($urandom), 1'b0, 1'b0);
            total++; if (act_rdy !== 1'b0) begin bad++; $display("FAIL bp_s_ready cyc=%0d got=%0b exp=0", i, act_rdy); end
            total++; if (bus.m_diff !== hold) begin bad++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", i, bus.m_diff, hold); end
        end
        cycle(1'b1, 14'($urandom), 1'b1, 1'b0);
        total++; if (act_rdy !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%0b exp=1", act_rdy); end
        total++; if (bus.m_valid !== 1'b1 || bus.m_diff !== md) begin
            bad++; $display("FAIL bp_release_word got=%0b/%h exp=1/%h", bus.m_valid, bus.m_diff, md);
        end
        for (int i = 0; i < 200; i++) begin
            cycle(($urandom % 4) != 0, 14'($urandom), ($urandom % 3) != 0, 1'b0);
            total++; if (act_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_s_ready cyc=%0d got=%0b exp=%0b", i, act_rdy, exp_rdy); end
            total++; if (bus.m_valid !== mv) begin bad++; $display("FAIL rnd_m_valid cyc=%0d got=%0b exp=%0b", i, bus.m_valid, mv); end
            total++; if (fill_cnt !== 4'(cnt)) begin bad++; $display("FAIL rnd_fill_cnt cyc=%0d got=%0d exp=%0d", i, fill_cnt, cnt); end
            if (mv) begin
                total++; if (bus.m_diff !== md) begin bad++; $display("FAIL rnd_m_diff cyc=%0d got=%h exp=%h", i, bus.m_diff, md); end
            end
        end
    endtask

    task automatic test_flush();
        int samp[10];
        logic [13:0] r;
        cycle(1'b1, 14'($urandom), 1'b1, 1'b0);
        cycle(1'b1, 14'($urandom), 1'b1, 1'b1);
        total++; if (act_rdy !== 1'b0) begin bad++; $display("FAIL flush_s_ready got=%0b exp=0", act_rdy); end
        total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL flush_m_valid got=%0b exp=0", bus.m_valid); end
        total++; if (fill_cnt !== 4'd0) begin bad++; $display("FAIL flush_fill_cnt got=%0d exp=0", fill_cnt); end
        for (int i = 0; i < 10; i++) begin
            r = 14'($urandom);
            samp[i] = int'($signed(r));
            cycle(1'b1, r, 1'b1, 1'b0);
            total++;
            if (bus.m_valid !== (i == 9)) begin
                bad++; $display("FAIL flush_refill accept=%0d got=%0b exp=%0b", i + 1, bus.m_valid, i == 9);
            end
        end
        for (int k = 0; k < 5; k++) begin
            total++;
            if (bus.m_diff[k*15 +: 15] !== 15'(samp[9-k] - samp[k])) begin
                bad++; $display("FAIL flush_d%0d got=%h exp=%h", k, bus.m_diff[k*15 +: 15], 15'(samp[9-k] - samp[k]));
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 14'($urandom), 1'b1, 1'b0);
        total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL arst_pre_valid got=%0b exp=1", bus.m_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL arst_m_valid got=%0b exp=0", bus.m_valid); end
        total++; if (bus.m_diff !== 75'd0) begin bad++; $display("FAIL arst_m_diff got=%h exp=0", bus.m_diff); end
        total++; if (fill_cnt !== 4'd0) begin bad++; $display("FAIL arst_fill_cnt got=%0d exp=0", fill_cnt); end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        test_fill("arst_fill");
    endtask

    task automatic test_idle_gaps();
        int pulses = 0;
        int accepts = 0;
        for (int i = 0; i < 30; i++) begin
            logic sv;
            sv = (i % 3 == 0);
            cycle(sv, 14'($urandom), 1'b1, 1'b0);
            if (sv && exp_rdy) accepts++;
            if (bus.m_valid === 1'b1) pulses++;
            total++; if (bus.m_valid !== sv) begin bad++; $display("FAIL idle_m_valid cyc=%0d got=%0b exp=%0b", i, bus.m_valid, sv); end
            if (sv) begin
                total++; if (bus.m_diff !== md) begin bad++; $display("FAIL idle_m_diff cyc=%0d got=%h exp=%h", i, bus.m_diff, md); end
            end
        end
        total++; if (pulses !== accepts) begin bad++; $display("FAIL idle_pulse_count got=%0d exp=%0d", pulses, accepts); end
    endtask

    initial begin
        test_reset();
        test_fill("fill");
        test_extremes();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_idle_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
